// File: rtl/snake_engine.sv
// Game-state engine for the greedy-snake design: owns the snake body, the
// segment-valid mask and the game status that feed the VGA renderer.
module snake_engine #(
  parameter int MAX_LEN       = 32,
  parameter int INIT_LEN      = 3,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   step_tick,
  input  logic                   start_pause,
  input  logic                   dir_valid,
  input  logic [1:0]             dir_req,
  input  logic [5:0]             apple_x,
  input  logic [5:0]             apple_y,
  output logic [6*MAX_LEN-1:0]   snake_x_temp,
  output logic [6*MAX_LEN-1:0]   snake_y_temp,
  output logic [MAX_LEN-1:0]     snake_piece_is_display,
  output logic [1:0]             game_status,
  output logic                   apple_eaten,
  output logic [5:0]             length
);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam int             FW         = $clog2(FLASH_TOGGLES + 1);
  localparam logic [FW-1:0]  FLASH_LAST = FW'(FLASH_TOGGLES);

  typedef enum logic [1:0] {
    PAUSED       = 2'b00,
    PLAYING      = 2'b01,
    DIE_FLASHING = 2'b10,
    INITIALIZING = 2'b11
  } state_t;

  state_t              state;
  logic [5:0]          seg_x [MAX_LEN];
  logic [5:0]          seg_y [MAX_LEN];
  logic [5:0]          init_x [MAX_LEN];
  logic [5:0]          init_y [MAX_LEN];
  logic [MAX_LEN-1:0]  mask;
  logic [MAX_LEN-1:0]  init_mask;
  logic [MAX_LEN-1:0]  full_mask;
  logic [1:0]          cur_dir;
  logic [1:0]          next_dir;
  logic [1:0]          ref_dir;
  logic [FW-1:0]       flash_cnt;
  logic [FW-1:0]       flash_nxt;

  logic [5:0]          nh_x;
  logic [5:0]          nh_y;
  logic                eat;
  logic                hit_border;
  logic                hit_body;
  logic                collide;
  logic                moving;

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      init_x[i]    = (i < INIT_LEN) ? 6'(24 - i) : 6'd0;
      init_y[i]    = (i < INIT_LEN) ? 6'd13 : 6'd0;
      init_mask[i] = (i < INIT_LEN);
      full_mask[i] = (i < int'(length));
    end
  end

  always_comb begin
    nh_x = seg_x[0];
    nh_y = seg_y[0];
    case (next_dir)
      DIR_UP:    nh_y = seg_y[0] - 6'd1;
      DIR_RIGHT: nh_x = seg_x[0] + 6'd1;
      DIR_DOWN:  nh_y = seg_y[0] + 6'd1;
      default:   nh_x = seg_x[0] - 6'd1;
    endcase
    eat        = (nh_x == apple_x) && (nh_y == apple_y);
    hit_border = (nh_x == 6'd0) || (nh_x == 6'd47) || (nh_y == 6'd0) || (nh_y == 6'd26);
    // The tail slot moves away this step unless the snake grows.
    hit_body   = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(length) && !(i == int'(length) - 1 && !eat) &&
          seg_x[i] == nh_x && seg_y[i] == nh_y)
        hit_body = 1'b1;
    end
    collide = hit_border || hit_body;
    moving  = step_tick && !collide;
    // Reversal is judged against the direction that will be committed after this cycle.
    ref_dir = moving ? next_dir : cur_dir;
  end

  assign flash_nxt = flash_cnt + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= INITIALIZING;
      seg_x       <= init_x;
      seg_y       <= init_y;
      mask        <= init_mask;
      length      <= 6'(INIT_LEN);
      cur_dir     <= DIR_RIGHT;
      next_dir    <= DIR_RIGHT;
      apple_eaten <= 1'b0;
      flash_cnt   <= '0;
    end else begin
      apple_eaten <= 1'b0;
      case (state)
        INITIALIZING: begin
          seg_x     <= init_x;
          seg_y     <= init_y;
          mask      <= init_mask;
          length    <= 6'(INIT_LEN);
          cur_dir   <= DIR_RIGHT;
          next_dir  <= DIR_RIGHT;
          flash_cnt <= '0;
          state     <= PAUSED;
        end
        PAUSED: begin
          if (start_pause) state <= PLAYING;
        end
        PLAYING: begin
          if (start_pause) begin
            state <= PAUSED;
          end else begin
            if (dir_valid && dir_req != (ref_dir ^ 2'b10)) next_dir <= dir_req;
            if (step_tick) begin
              if (collide) begin
                state     <= DIE_FLASHING;
                flash_cnt <= '0;
              end else begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                  seg_x[i] <= seg_x[i-1];
                  seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= nh_x;
                seg_y[0] <= nh_y;
                cur_dir  <= next_dir;
                if (eat) begin
                  apple_eaten <= 1'b1;
                  if (int'(length) < MAX_LEN) begin
                    length <= length + 6'd1;
                    mask   <= {mask[MAX_LEN-2:0], 1'b1};
                  end
                end
              end
            end
          end
        end
        default: begin
          if (step_tick) begin
            if (flash_nxt == FLASH_LAST) begin
              state     <= INITIALIZING;
              mask      <= full_mask;
              flash_cnt <= '0;
            end else begin
              mask      <= mask ^ full_mask;
              flash_cnt <= flash_nxt;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    snake_x_temp = '0;
    snake_y_temp = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      snake_x_temp[6*i +: 6] = seg_x[i];
      snake_y_temp[6*i +: 6] = seg_y[i];
    end
  end

  assign snake_piece_is_display = mask;
  assign game_status            = state;

endmodule
